// File: rtl/pixie_pkg.sv
// Shared definitions for the pixie video shaper: lock FSM encoding,
// config register map, colour type and reset colours.
package pixie_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lock_state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam logic [2:0] CFG_FG_R = 3'd0;
    localparam logic [2:0] CFG_FG_G = 3'd1;
    localparam logic [2:0] CFG_FG_B = 3'd2;
    localparam logic [2:0] CFG_BG_R = 3'd3;
    localparam logic [2:0] CFG_BG_G = 3'd4;
    localparam logic [2:0] CFG_BG_B = 3'd5;
    localparam logic [2:0] CFG_CTRL = 3'd6;

    localparam int CTRL_DIM = 0;
    localparam int CTRL_INV = 1;

    localparam rgb_t FG_RESET = 24'hFF_FF_FF;
    localparam rgb_t BG_RESET = 24'h00_00_00;

    localparam logic [8:0] LINE_SAT = 9'd511;

    function automatic rgb_t dim_rgb(input rgb_t c, input int shift);
        rgb_t d;
        d.r = c.r >> shift;
        d.g = c.g >> shift;
        d.b = c.b >> shift;
        return d;
    endfunction

endpackage

// File: rtl/pixie_sync_lock.sv
// Sync edge detection, saturating line counter and the frame lock FSM
// that decides whether the incoming timing is stable enough to show video.
module pixie_sync_lock
    import pixie_pkg::*;
#(
    parameter int MIN_LINES   = 200,
    parameter int MAX_LINES   = 320,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync,
    input  logic       vsync,
    output logic       locked,
    output logic [8:0] line_count
);

    localparam int GOOD_W = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam logic [8:0]        MIN_LC    = 9'(MIN_LINES);
    localparam logic [8:0]        MAX_LC    = 9'(MAX_LINES);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_FRAMES - 1);

    lock_state_e       state_q, state_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [8:0]        line_count_q, line_count_d;
    logic              hs_prev_q, hs_prev_d;
    logic              vs_prev_q, vs_prev_d;
    logic              locked_q, locked_d;

    logic hs_rise;
    logic vs_rise;
    logic in_range;
    logic timeout;

    always_comb begin
        hs_prev_d = hsync;
        vs_prev_d = vsync;
        hs_rise   = hsync & ~hs_prev_q;
        vs_rise   = vsync & ~vs_prev_q;

        // A VSync rise always wins over a coincident HSync rise.
        line_count_d = line_count_q;
        if (vs_rise) begin
            line_count_d = '0;
        end else if (hs_rise && (line_count_q != LINE_SAT)) begin
            line_count_d = line_count_q + 9'd1;
        end

        in_range = (line_count_q >= MIN_LC) && (line_count_q <= MAX_LC);
        timeout  = (line_count_q > MAX_LC);

        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            SEARCH: begin
                if (vs_rise) begin
                    state_d = VERIFY;
                    good_d  = '0;
                end
            end
            VERIFY: begin
                if (vs_rise) begin
                    if (in_range) begin
                        if (good_q == GOOD_LAST) begin
                            state_d = LOCKED;
                            good_d  = '0;
                        end else begin
                            good_d = good_q + 1'b1;
                        end
                    end else begin
                        good_d = '0;
                    end
                end else if (timeout) begin
                    state_d = SEARCH;
                    good_d  = '0;
                end
            end
            LOCKED: begin
                if (vs_rise) begin
                    if (line_count_q < MIN_LC) begin
                        state_d = SEARCH;
                    end
                end else if (timeout) begin
                    state_d = SEARCH;
                end
            end
            default: begin
                state_d = SEARCH;
                good_d  = '0;
            end
        endcase

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SEARCH;
            good_q       <= '0;
            line_count_q <= '0;
            hs_prev_q    <= 1'b0;
            vs_prev_q    <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            good_q       <= good_d;
            line_count_q <= line_count_d;
            hs_prev_q    <= hs_prev_d;
            vs_prev_q    <= vs_prev_d;
            locked_q     <= locked_d;
        end
    end

    assign locked     = locked_q;
    assign line_count = line_count_q;

endmodule

// File: rtl/pixie_video_shaper.sv
// Video output shaper: config registers plus a two-stage pixel pipeline
// that colours, blanks and dims the back-end video once sync is locked.
module pixie_video_shaper
    import pixie_pkg::*;
#(
    parameter int MIN_LINES   = 200,
    parameter int MAX_LINES   = 320,
    parameter int LOCK_FRAMES = 2,
    parameter int DIM_SHIFT   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_ce,
    input  logic       video,
    input  logic       HSync,
    input  logic       VSync,
    input  logic       HBlank,
    input  logic       VBlank,
    input  logic       cfg_we,
    input  logic [2:0] cfg_addr,
    input  logic [7:0] cfg_data,
    output logic [7:0] R,
    output logic [7:0] G,
    output logic [7:0] B,
    output logic       HSync_o,
    output logic       VSync_o,
    output logic       HBlank_o,
    output logic       VBlank_o,
    output logic       de_o,
    output logic       ce_pix_o,
    output logic       locked,
    output logic [8:0] line_count
);

    rgb_t       fg_q, fg_d;
    rgb_t       bg_q, bg_d;
    logic [1:0] ctrl_q, ctrl_d;

    rgb_t s1_color_q, s1_color_d;
    logic s1_dim_q, s1_dim_d;
    logic s1_hs_q, s1_hs_d;
    logic s1_vs_q, s1_vs_d;
    logic s1_hb_q, s1_hb_d;
    logic s1_vb_q, s1_vb_d;
    logic s1_de_q, s1_de_d;
    logic s1_ce_q, s1_ce_d;

    rgb_t out_color_q, out_color_d;
    logic out_hs_q, out_hs_d;
    logic out_vs_q, out_vs_d;
    logic out_hb_q, out_hb_d;
    logic out_vb_q, out_vb_d;
    logic out_de_q, out_de_d;
    logic out_ce_q, out_ce_d;

    logic pixel;

    pixie_sync_lock #(
        .MIN_LINES  (MIN_LINES),
        .MAX_LINES  (MAX_LINES),
        .LOCK_FRAMES(LOCK_FRAMES)
    ) u_sync_lock (
        .clk       (clk),
        .reset     (reset),
        .hsync     (HSync),
        .vsync     (VSync),
        .locked    (locked),
        .line_count(line_count)
    );

    always_comb begin
        fg_d   = fg_q;
        bg_d   = bg_q;
        ctrl_d = ctrl_q;
        if (cfg_we) begin
            case (cfg_addr)
                CFG_FG_R: fg_d.r = cfg_data;
                CFG_FG_G: fg_d.g = cfg_data;
                CFG_FG_B: fg_d.b = cfg_data;
                CFG_BG_R: bg_d.r = cfg_data;
                CFG_BG_G: bg_d.g = cfg_data;
                CFG_BG_B: bg_d.b = cfg_data;
                CFG_CTRL: ctrl_d = cfg_data[1:0];
                default:  ;
            endcase
        end

        // Stage 1 captures the dim enable alongside the colour so both
        // config fields come from the same register snapshot.
        pixel      = video ^ ctrl_q[CTRL_INV];
        s1_color_d = pixel ? fg_q : bg_q;
        s1_dim_d   = ctrl_q[CTRL_DIM];
        s1_hs_d    = HSync;
        s1_vs_d    = VSync;
        s1_hb_d    = HBlank;
        s1_vb_d    = VBlank;
        s1_de_d    = ~(HBlank | VBlank);
        s1_ce_d    = pix_ce;

        out_color_d = '0;
        if (s1_de_q && locked) begin
            if (s1_dim_q && line_count[0]) begin
                out_color_d = dim_rgb(s1_color_q, DIM_SHIFT);
            end else begin
                out_color_d = s1_color_q;
            end
        end
        out_hs_d = s1_hs_q;
        out_vs_d = s1_vs_q;
        out_hb_d = s1_hb_q;
        out_vb_d = s1_vb_q;
        out_de_d = s1_de_q;
        out_ce_d = s1_ce_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fg_q        <= FG_RESET;
            bg_q        <= BG_RESET;
            ctrl_q      <= '0;
            s1_color_q  <= '0;
            s1_dim_q    <= 1'b0;
            s1_hs_q     <= 1'b0;
            s1_vs_q     <= 1'b0;
            s1_hb_q     <= 1'b0;
            s1_vb_q     <= 1'b0;
            s1_de_q     <= 1'b0;
            s1_ce_q     <= 1'b0;
            out_color_q <= '0;
            out_hs_q    <= 1'b0;
            out_vs_q    <= 1'b0;
            out_hb_q    <= 1'b0;
            out_vb_q    <= 1'b0;
            out_de_q    <= 1'b0;
            out_ce_q    <= 1'b0;
        end else begin
            fg_q        <= fg_d;
            bg_q        <= bg_d;
            ctrl_q      <= ctrl_d;
            s1_color_q  <= s1_color_d;
            s1_dim_q    <= s1_dim_d;
            s1_hs_q     <= s1_hs_d;
            s1_vs_q     <= s1_vs_d;
            s1_hb_q     <= s1_hb_d;
            s1_vb_q     <= s1_vb_d;
            s1_de_q     <= s1_de_d;
            s1_ce_q     <= s1_ce_d;
            out_color_q <= out_color_d;
            out_hs_q    <= out_hs_d;
            out_vs_q    <= out_vs_d;
            out_hb_q    <= out_hb_d;
            out_vb_q    <= out_vb_d;
            out_de_q    <= out_de_d;
            out_ce_q    <= out_ce_d;
        end
    end

    assign R        = out_color_q.r;
    assign G        = out_color_q.g;
    assign B        = out_color_q.b;
    assign HSync_o  = out_hs_q;
    assign VSync_o  = out_vs_q;
    assign HBlank_o = out_hb_q;
    assign VBlank_o = out_vb_q;
    assign de_o     = out_de_q;
    assign ce_pix_o = out_ce_q;

endmodule

// File: doc/pixie_video_shaper.md
PIXIE_VIDEO_SHAPER -- requirements
Module: pixie_video_shaper

Interface
REQ-001 Parameter MIN_LINES, default 200: fewest lines accepted as a valid frame.
REQ-002 Parameter MAX_LINES, default 320: most lines accepted as a valid frame; also the loss-of-sync timeout.
REQ-003 Parameter LOCK_FRAMES, default 2: consecutive valid frames needed to lock.
REQ-004 Parameter DIM_SHIFT, default 1: right-shift applied to colour on dimmed lines.
REQ-005 clk  in  1  video clock; the block's only clock, all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 pix_ce  in  1  pixel clock enable from the display back end.
REQ-008 video, HSync, VSync, HBlank, VBlank  in  1 each  back-end pixel and timing signals, active-high.
REQ-009 cfg_we  in  1  config write strobe; cfg_addr  in  3  register select; cfg_data  in  8  write data.
REQ-010 R, G, B  out  8 each  colour output.
REQ-011 HSync_o, VSync_o, HBlank_o, VBlank_o, de_o, ce_pix_o  out  1 each  delayed timing; de_o = !(HBlank|VBlank).
REQ-012 locked  out  1  sync-lock status; line_count  out  9  lines since last VSync rise.

Function
REQ-013 Config registers: addr 0..2 = fg R/G/B, 3..5 = bg R/G/B, 6 = ctrl (bit0 scanline dim, bit1 invert video); addr 7 ignored.
REQ-014 A config write takes effect on the cycle after cfg_we, with no glitch on other registers.
REQ-015 Two-stage pipeline: every output equals the input function two clk cycles earlier, registered every clk regardless of pix_ce.
REQ-016 Stage 1 registers inputs and selects colour: pixel = video XOR ctrl[1]; fg if pixel=1, else bg.
REQ-017 Stage 2 applies blanking and dimming: RGB = 0 when blanked or locked=0; RGB >> DIM_SHIFT per channel when ctrl[0]=1 and line_count[0]=1.
REQ-018 HSync/VSync rising edges are detected from registered previous values; the edge registers reset to 0.
REQ-019 line_count increments on each HSync rise, clears to 0 on a VSync rise, and saturates at 511.
REQ-020 HSync rise and VSync rise in the same cycle: VSync wins and line_count = 0.
REQ-021 Lock FSM states: SEARCH, VERIFY, LOCKED; good-frame counter width is ceil(log2(LOCK_FRAMES+1)).
REQ-022 SEARCH: on the first VSync rise go to VERIFY with good = 0.
REQ-023 VERIFY: on a VSync rise with MIN_LINES <= line_count <= MAX_LINES, good increments; on reaching LOCK_FRAMES go to LOCKED.
REQ-024 VERIFY: an out-of-range VSync rise clears good and stays in VERIFY.
REQ-025 LOCKED: a VSync rise with line_count < MIN_LINES, or line_count > MAX_LINES before any VSync, goes to SEARCH.
REQ-026 The timeout of REQ-025 also applies in VERIFY, returning to SEARCH.
REQ-027 locked = 1 only in LOCKED, registered, asserted the cycle after the transition.
REQ-028 Syncs, blanks, de_o and ce_pix_o always pass through with 2-cycle latency, independent of lock state.

Reset
REQ-029 On reset: R=G=B=0, all timing outputs 0, locked=0, line_count=0, FSM=SEARCH, good=0, both pipeline stages cleared.
REQ-030 Reset defaults: fg = FF/FF/FF, bg = 00/00/00, ctrl = 0; reset overrides a simultaneous cfg_we.
REQ-031 Reset mid-frame forces SEARCH; relock needs LOCK_FRAMES further valid frames after the next VSync rise.

Structure
REQ-032 Shared pixie package holds the FSM state encoding, config address constants and reset colour constants.
REQ-033 One sub-module, pixie_sync_lock, holds the edge detectors, line counter and lock FSM; the top module holds the config registers and pixel pipeline.

Verification
REQ-034 Reset, then video=1, blanks=0, unlocked -> RGB=000000 two cycles later; HSync_o mirrors HSync delayed 2.
REQ-035 Three frames of 262 lines -> locked rises after the 2nd full frame's VSync rise; white/black pixels then appear 2 cycles after video.
REQ-036 Locked, write bg=0x20/0x40/0x80 at addr 3..5, ctrl=1 -> even lines bg 204080, odd lines 102040.
REQ-037 Locked, HSync rises continue, VSync withheld -> locked falls when line_count passes 320; line_count saturates at 511.
REQ-038 Locked, then one frame of 100 lines -> SEARCH, locked=0; ctrl=2 inverts pixels after relock.
REQ-039 HSync and VSync rise in the same cycle -> line_count=0; reset asserted mid-frame -> all outputs 0 next cycle.
